// File: rtl/nios_setup_cpu_debug_pkg.sv
// Shared definitions for the CPU-side debug monitor: FSM state encoding and
// bit positions of the fields carried in the decoded JTAG data word (jdo).
package nios_setup_cpu_debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mon_state_e;

  localparam int JDO_W          = 38;
  localparam int JDO_RDEN_BIT   = 34;  // ocimem_a: also start a read
  localparam int JDO_ERRCLR_BIT = 35;  // ocimem_a: clear sticky error
  localparam int JDO_DATA_LSB   = 3;   // ocimem_b: write data jdo[34:3]
  localparam int JDO_ADDR_LSB   = 2;   // ocimem_a: word address

endpackage

// File: rtl/nios_setup_cpu_debug_mon_timeout.sv
// Stall watchdog for a debug memory transaction. Counts stalled cycles while
// a request is outstanding and flags the cycle in which the TIMEOUT-th
// consecutive stall is seen, so the controller can abort on that edge.
module nios_setup_cpu_debug_mon_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy_i,    // FSM is in RD or WR
  input  logic stall_i,   // mem_waitrequest
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Abort when this stalled cycle would be the TIMEOUT-th one.
  assign expired_o = busy_i & stall_i & (cnt_q == CW'(TIMEOUT - 1));

  // Counter sits at zero while idle, so every transaction starts from 0.
  always_ff @(posedge clk) begin
    if (!reset_n || !busy_i) begin
      cnt_q <= '0;
    end else if (stall_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/nios_setup_cpu_debug_mon_ctrl.sv
// CPU-side debug monitor controller. Turns decoded JTAG commands into single
// word reads/writes on the debug memory bus and maintains MonAReg/MonDReg.
// Optional build macro DEBUG_MON_TIMEOUT_EN adds a stall watchdog that aborts
// a transaction after TIMEOUT stalled cycles and flags monitor_error.
module nios_setup_cpu_debug_mon_ctrl
  import nios_setup_cpu_debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_e        state_q;
  logic [ADDR_W-1:0] mon_a_q, mem_addr_q;
  logic [DATA_W-1:0] mon_d_q, mem_wd_q;
  logic              mem_rd_q, mem_wr_q, ready_q, err_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_data;
  logic [ADDR_W-1:0] mon_a_inc_d;
  logic              busy, any_strobe, err_clr, timeout_hit;

  assign jdo_addr    = jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
  assign jdo_data    = jdo[DATA_W+JDO_DATA_LSB-1:JDO_DATA_LSB];
  assign mon_a_inc_d = mon_a_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
  assign busy        = (state_q != IDLE);
  assign any_strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign err_clr     = take_action_ocimem_a & jdo[JDO_ERRCLR_BIT];

`ifdef DEBUG_MON_TIMEOUT_EN
  nios_setup_cpu_debug_mon_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .busy_i    (busy),
    .stall_i   (mem_waitrequest),
    .expired_o (timeout_hit)
  );
  logic unused_cfg;
  assign unused_cfg = 1'b0;
`else
  // Without the watchdog a stalled transaction waits forever.
  assign timeout_hit = 1'b0;
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
`endif

  // jdo bits not consumed by any command field.
  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[JDO_W-1:JDO_ERRCLR_BIT+1], jdo[JDO_ADDR_LSB-1:0]};

  // Command FSM with all bus/monitor outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      // Commands arriving mid-transaction are dropped and flagged; an
      // explicit clear request wins over that flag in the same cycle.
      if (busy && any_strobe) err_q <= 1'b1;
      if (err_clr)            err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (take_action_ocimem_b) begin
            mon_d_q    <= jdo_data;
            mem_wd_q   <= jdo_data;
            mem_addr_q <= mon_a_q;
            mem_wr_q   <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= WR;
          end else if (take_action_ocimem_a) begin
            mon_a_q <= jdo_addr;
            if (jdo[JDO_RDEN_BIT]) begin
              mem_addr_q <= jdo_addr;
              mem_rd_q   <= 1'b1;
              ready_q    <= 1'b0;
              state_q    <= RD;
            end
          end else if (take_no_action_ocimem_a) begin
            mem_addr_q <= mon_a_q;
            mem_rd_q   <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= RD;
          end
        end
        RD: begin
          if (!mem_waitrequest) begin
            mon_d_q  <= mem_readdata;
            mon_a_q  <= mon_a_inc_d;
            mem_rd_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end else if (timeout_hit) begin
            mem_rd_q <= 1'b0;
            err_q    <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        WR: begin
          if (!mem_waitrequest) begin
            mon_a_q  <= mon_a_inc_d;
            mem_wr_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end else if (timeout_hit) begin
            mem_wr_q <= 1'b0;
            err_q    <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address   = mem_addr_q;
  assign mem_read      = mem_rd_q;
  assign mem_write     = mem_wr_q;
  assign mem_writedata = mem_wd_q;
  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_nios_setup_cpu_debug_mon_ctrl.sv
// Directed bench for the debug monitor controller: reset state, read, write
// with stalls and address wrap, busy-strobe error handling, strobe priority,
// reset mid-transaction and (when built with the macro) the stall watchdog.
module tb_nios_setup_cpu_debug_mon_ctrl;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        a, na, b;
  logic [ADDR_W-1:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_waitrequest;
  logic [31:0] MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int errors = 0;

  nios_setup_cpu_debug_mon_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (a),
    .take_no_action_ocimem_a (na),
    .take_action_ocimem_b    (b),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_readdata            (mem_readdata),
    .mem_waitrequest         (mem_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs and outputs are handled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic errclr, input logic rden,
                                        input logic [ADDR_W-1:0] addr);
    logic [37:0] v;
    v = '0;
    v[35] = errclr;
    v[34] = rden;
    v[ADDR_W+1:2] = addr;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    return {3'b000, data, 3'b000};
  endfunction

  initial begin
    reset_n = 1'b0; jdo = '0; a = 0; na = 0; b = 0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ready", monitor_ready, 1);
    chk("rst_err",   monitor_error, 0);
    chk("rst_areg",  MonAReg, 0);
    chk("rst_dreg",  MonDReg, 0);
    chk("rst_rd",    mem_read, 0);
    chk("rst_wr",    mem_write, 0);
    chk("rst_addr",  mem_address, 0);
    chk("rst_wd",    mem_writedata, 0);
    reset_n = 1'b1;
    tick();

    // Load address 0x10 and read with no wait states
    mem_readdata = 32'hDEADBEEF;
    jdo = jdo_a(1'b0, 1'b1, 8'h10); a = 1;
    tick(); a = 0;
    chk("rd1_req",   mem_read, 1);
    chk("rd1_addr",  mem_address, 8'h10);
    chk("rd1_areg",  MonAReg, 8'h10);
    chk("rd1_busy",  monitor_ready, 0);
    tick();
    chk("rd1_done",  mem_read, 0);
    chk("rd1_dreg",  MonDReg, 32'hDEADBEEF);
    chk("rd1_ainc",  MonAReg, 8'h11);
    chk("rd1_ready", monitor_ready, 1);
    chk("rd1_err",   monitor_error, 0);

    // Address-only load to 0xFF, then write stalled for 3 cycles
    jdo = jdo_a(1'b0, 1'b0, 8'hFF); a = 1;
    tick(); a = 0;
    chk("ld_areg",  MonAReg, 8'hFF);
    chk("ld_noreq", mem_read, 0);
    chk("ld_ready", monitor_ready, 1);
    mem_waitrequest = 1'b1;
    jdo = jdo_b(32'h12345678); b = 1;
    tick(); b = 0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_hold",  mem_write, 1);
      chk("wr_addr",  mem_address, 8'hFF);
      chk("wr_data",  mem_writedata, 32'h12345678);
      chk("wr_busy",  monitor_ready, 0);
      if (i == 3) mem_waitrequest = 1'b0;
      tick();
    end
    chk("wr_done",  mem_write, 0);
    chk("wr_wrap",  MonAReg, 8'h00);
    chk("wr_dreg",  MonDReg, 32'h12345678);
    chk("wr_ready", monitor_ready, 1);
    chk("wr_err",   monitor_error, 0);

    // Stalled read with a strobe during the stall
    mem_readdata = 32'hCAFEF00D; mem_waitrequest = 1'b1;
    na = 1;
    tick(); na = 0;
    chk("st_req",  mem_read, 1);
    chk("st_addr", mem_address, 8'h00);
    tick();
    na = 1;
    tick(); na = 0;
    chk("st_err",    monitor_error, 1);
    chk("st_stillrq", mem_read, 1);
    chk("st_addr2",  mem_address, 8'h00);
    mem_waitrequest = 1'b0;
    tick();
    chk("st_done",  mem_read, 0);
    chk("st_dreg",  MonDReg, 32'hCAFEF00D);
    chk("st_ainc",  MonAReg, 8'h01);
    chk("st_ready", monitor_ready, 1);
    tick();
    chk("st_sticky", monitor_error, 1);
    jdo = jdo_a(1'b1, 1'b0, 8'h20); a = 1;
    tick(); a = 0;
    chk("clr_err",  monitor_error, 0);
    chk("clr_areg", MonAReg, 8'h20);
    chk("clr_rd",   mem_read, 0);

    // Same-cycle write and no-action read: write wins, no error
    jdo = jdo_b(32'hA5A5A5A5); b = 1; na = 1;
    tick(); b = 0; na = 0;
    chk("pri_wr",   mem_write, 1);
    chk("pri_rd",   mem_read, 0);
    chk("pri_addr", mem_address, 8'h20);
    tick();
    chk("pri_done", mem_write, 0);
    chk("pri_err",  monitor_error, 0);
    chk("pri_ainc", MonAReg, 8'h21);

    // Reset while a write is stalled
    mem_waitrequest = 1'b1;
    jdo = jdo_b(32'h0BADCAFE); b = 1;
    tick(); b = 0;
    chk("rm_wr", mem_write, 1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("rm_wr0",   mem_write, 0);
    chk("rm_areg",  MonAReg, 0);
    chk("rm_ready", monitor_ready, 1);
    chk("rm_dreg",  MonDReg, 0);
    reset_n = 1'b1;
    tick();

`ifdef DEBUG_MON_TIMEOUT_EN
    // Read stuck on waitrequest is aborted after TIMEOUT=4 stalled cycles
    jdo = jdo_a(1'b0, 1'b1, 8'h05); a = 1;
    tick(); a = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_hold", mem_read, 1);
      tick();
    end
    chk("to_drop",  mem_read, 0);
    chk("to_err",   monitor_error, 1);
    chk("to_areg",  MonAReg, 8'h05);
    chk("to_dreg",  MonDReg, 0);
    chk("to_ready", monitor_ready, 1);
`else
    // Without the watchdog a stalled read simply keeps waiting
    jdo = jdo_a(1'b0, 1'b1, 8'h05); a = 1;
    tick(); a = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("nto_hold", mem_read, 1);
    chk("nto_err",  monitor_error, 0);
    mem_waitrequest = 1'b0;
    tick();
    chk("nto_done", mem_read, 0);
    chk("nto_ainc", MonAReg, 8'h06);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_setup_cpu_debug_mon_ctrl.md
Name: nios_setup_cpu_debug_mon_ctrl

Overview:
- Consumes the decoded JTAG debug commands (jdo plus take_action/take_no_action strobes) on the CPU clock side of the debug slave.
- Turns them into single-word read/write transactions on the on-chip debug memory bus.
- Maintains the monitor address and data registers.
- Returns MonDReg, monitor_ready and monitor_error, which feed back upstream into the debug slave capture path.

Parameters:
- ADDR_W, 8, word-address width of the debug memory (MonAReg width).
- DATA_W, 32, data width; fixed at 32 to match MonDReg.
- TIMEOUT, 255, cycles a bus transaction may wait before being aborted as an error (used only with the optional feature).

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- jdo  in  38  decoded JTAG data word, valid when any strobe is high.
- take_action_ocimem_a  in  1  address-load strobe; jdo[34]=1 also starts a read.
- take_no_action_ocimem_a  in  1  read at current MonAReg, then auto-increment.
- take_action_ocimem_b  in  1  write jdo[34:3] at MonAReg, then auto-increment.
- mem_address  out  ADDR_W  debug memory word address.
- mem_read  out  1  read request, held until accepted.
- mem_write  out  1  write request, held until accepted.
- mem_writedata  out  32  write data.
- mem_readdata  in  32  read data, valid in the cycle the read is accepted.
- mem_waitrequest  in  1  slave stall.
- MonDReg  out  32  monitor data register.
- MonAReg  out  ADDR_W  monitor address register.
- monitor_ready  out  1  high when idle and the last command has completed.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset values (applied on the clk edge while reset_n=0): MonAReg=0, MonDReg=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, monitor_ready=1, monitor_error=0, FSM=IDLE.
- FSM states: IDLE, RD, WR.
- IDLE + take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W+1:2].
  - If jdo[34]=1: go to RD, assert mem_read with mem_address = the newly loaded address, and clear monitor_ready.
  - Otherwise stay in IDLE; monitor_ready stays 1.
- IDLE + take_no_action_ocimem_a: go to RD at the current MonAReg; monitor_ready <= 0.
- IDLE + take_action_ocimem_b: MonDReg <= jdo[34:3]; go to WR; mem_writedata <= jdo[34:3]; mem_address <= MonAReg; monitor_ready <= 0.
- Strobe priority if several are high in the same cycle: ocimem_b > ocimem_a > no_action_a. Lower-priority strobes are ignored and are not an error.
- Request timing:
  - The request is asserted the cycle after the strobe.
  - Transfer completes in the first cycle where the request is high and mem_waitrequest=0.
  - Request, address and data are held stable while mem_waitrequest=1.
- RD completion: MonDReg <= mem_readdata; MonAReg <= MonAReg+1; mem_read <= 0; monitor_ready <= 1; go to IDLE.
- WR completion: MonAReg <= MonAReg+1; mem_write <= 0; monitor_ready <= 1; go to IDLE.
- Latency: with zero wait states, monitor_ready returns to 1 two cycles after the strobe.
- MonAReg wraps modulo 2^ADDR_W; all-ones increments to 0, and this is not an error.
- Any strobe arriving in RD or WR is dropped and sets monitor_error. The in-flight transaction is unaffected.
- monitor_error clears only on reset_n, or on take_action_ocimem_a with jdo[35]=1. That clear is honoured in any state; the address load itself happens only in IDLE.
- Reset mid-transaction: request drops on the reset edge and all state returns to reset values. No completion side effects occur.

Optional Feature:
- Macro: DEBUG_MON_TIMEOUT_EN.
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter starts at 0 on entry to RD or WR and increments each stalled cycle.
  - When it reaches TIMEOUT with mem_waitrequest still 1: drop the request, set monitor_error, leave MonDReg and MonAReg unchanged, set monitor_ready=1, go to IDLE.
- Undefined: no counter exists; the FSM waits indefinitely on mem_waitrequest.

Decomposition:
- Shared package nios_setup_cpu_debug_pkg holds:
  - the FSM state enum (IDLE/RD/WR);
  - jdo field constants (JDO_RDEN_BIT=34, JDO_ERRCLR_BIT=35, JDO_DATA_LSB=3, JDO_ADDR_LSB=2).
- One natural sub-module, nios_setup_cpu_debug_mon_timeout: the timeout counter, instantiated only under DEBUG_MON_TIMEOUT_EN.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[ADDR_W+1:2]=0x10 and jdo[34]=1, no wait, mem_readdata=0xDEADBEEF -> mem_read high 1 cycle at address 0x10; MonDReg=0xDEADBEEF; MonAReg=0x11; monitor_ready back to 1 two cycles after the strobe.
- take_action_ocimem_b with jdo[34:3]=0x12345678, MonAReg=0xFF (ADDR_W=8), waitrequest held for 3 cycles -> mem_write held 4 cycles with stable address/data; MonAReg wraps to 0x00; no error.
- Read stalled by waitrequest, with take_no_action_ocimem_a pulsed mid-stall -> monitor_error=1; the read still completes normally; monitor_error stays 1 until take_action_ocimem_a with jdo[35]=1.
- Same-cycle take_action_ocimem_b and take_no_action_ocimem_a -> only the write is issued; monitor_error stays 0.
- reset_n=0 asserted while mem_write is stalled -> next edge gives mem_write=0, MonAReg=0, monitor_ready=1.
- With DEBUG_MON_TIMEOUT_EN, TIMEOUT=4, waitrequest stuck at 1 -> request drops after 4 stalled cycles; monitor_error=1; MonAReg unchanged.
